// File: rtl/nios_debug_capture.sv
// nios_debug_capture: captures 24-bit debug events into a small FIFO and
// presents the head as a registered 32-bit status word for a Nios PIO input.
// Software pops the head by toggling ack_toggle (any level change pops once).
// debug_word = {valid, overflow, seq[5:0], payload[23:0]}; [29:0] are zero when empty.
// Optional feature macro: NIOS_DEBUG_CAPTURE_DEDUP_EN suppresses a capture
// whose payload repeats the last accepted payload.
module nios_debug_capture #(
   parameter int DEPTH = 8,
   parameter int AW    = 3
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        capture,
   input  logic [23:0] capture_data,
   input  logic        ack_toggle,
   input  logic        clear,
   output logic [31:0] debug_word
);

   logic [29:0] mem [DEPTH];
   logic [AW:0] wr_ptr;
   logic [AW:0] rd_ptr;
   logic [5:0]  seq;
   logic        overflow;
   logic        ack_prev;

   logic        empty;
   logic        full;
   logic        pop_evt;
   logic        pop_ok;
   logic        dup;
   logic        cap_eff;
   logic        push_ok;

   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) &&
                    (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign pop_evt = ack_toggle ^ ack_prev;
   // A pop on an empty FIFO is ignored; full implies non-empty, so a pop
   // while full always frees the slot the simultaneous push will use.
   assign pop_ok  = pop_evt && !empty;
   assign cap_eff = capture && !dup;
   assign push_ok = cap_eff && (!full || pop_ok);

`ifdef NIOS_DEBUG_CAPTURE_DEDUP_EN
   logic [23:0] last_payload;
   logic        last_valid;

   assign dup = last_valid && (capture_data == last_payload);

   // Track the payload of the last accepted capture; drops do not update it.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         last_payload <= 24'd0;
         last_valid   <= 1'b0;
      end else if (clear) begin
         last_valid   <= 1'b0;
      end else if (push_ok) begin
         last_payload <= capture_data;
         last_valid   <= 1'b1;
      end
   end
`else
   assign dup = 1'b0;
`endif

   // Pointer, sequence, overflow and ack-edge bookkeeping.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         seq      <= 6'd0;
         overflow <= 1'b0;
         ack_prev <= 1'b0;
      end else if (clear) begin
         // Re-sync ack_prev so the current ack level does not look like a pop.
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         seq      <= 6'd0;
         overflow <= 1'b0;
         ack_prev <= ack_toggle;
      end else begin
         ack_prev <= ack_toggle;
         if (push_ok) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop_ok) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         // Every non-suppressed capture consumes a sequence number, so gaps reveal drops.
         if (cap_eff) begin
            seq <= seq + 6'd1;
         end
         if (cap_eff && full && !pop_ok) begin
            overflow <= 1'b1;
         end
      end
   end

   // Entry storage; contents need no reset since empty pointers hide them.
   always_ff @(posedge clk) begin
      if (push_ok && !clear) begin
         mem[wr_ptr[AW-1:0]] <= {seq, capture_data};
      end
   end

   // Status word is built only from registered state, one edge behind the FIFO.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         debug_word <= 32'h0000_0000;
      end else if (empty) begin
         debug_word <= {1'b0, overflow, 30'd0};
      end else begin
         debug_word <= {1'b1, overflow, mem[rd_ptr[AW-1:0]]};
      end
   end

endmodule
